avl2mem: RTL and testbench

AVL2MEM -- requirements
Module: avl2mem

---
 rtl/avl2mem_if.sv | 25 ++
 rtl/avl2mem.sv | 120 ++++++++++++
 tb/tb_avl2mem.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/avl2mem_if.sv
// Avalon-MM slave bus bundle for avl2mem: address, writedata, byteenable,
// read, write (initiator side) and readdata, waitrequest (target side).
`timescale 1ns/1ps
interface avl2mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] writedata;
    logic [3:0]            byteenable;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  waitrequest;

    modport master (
        output address, writedata, byteenable, read, write,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, byteenable, read, write,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avl2mem.sv
// Avalon-MM slave backed by an internal word RAM with programmable wait
// states. Ports: clk, reset (async, active-low), bus (avl2mem_if.slave).
// Option AVL2MEM_ERRCNT_EN adds err_count[7:0] (saturating error count).
`timescale 1ns/1ps
module avl2mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       reset,
`ifdef AVL2MEM_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    avl2mem_if.slave   bus
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic                  w_req;
    logic [IW-1:0]         w_idx;
    logic [MW-1:0]         w_midx;
    logic                  w_inrange;
    logic                  w_rdok;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rword;
    logic                  w_unused;

    assign w_req     = bus.read | bus.write;
    assign w_idx     = bus.address[ADDR_WIDTH-1:2];
    assign w_midx    = w_idx[MW-1:0];
    assign w_inrange = (w_idx < IW'(MEM_WORDS));
    // read+write together is handled as a write, so it never returns data
    assign w_rdok    = bus.read & ~bus.write & w_inrange;
    assign w_err     = ~w_inrange | (bus.read & bus.write);
    assign w_rword   = w_rdok ? r_mem[w_midx] : '0;
    assign w_unused  = ^bus.address[1:0];

    assign bus.waitrequest = w_req & (r_state != S_ACK);
    assign bus.readdata    = r_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_cnt <= 4'(WAIT_STATES);
                        if (WAIT_STATES > 0) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_ACK;
                            r_rdata <= w_rword;
                        end
                    end
                end
                S_WAIT: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt <= 4'd1) begin
                        r_state <= S_ACK;
                        r_rdata <= w_rword;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_rdata <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    // RAM is not reset; a reset forces IDLE so no write can escape it
    always_ff @(posedge clk) begin
        if (r_state == S_ACK && bus.write && w_inrange) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    r_mem[w_midx][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

`ifdef AVL2MEM_ERRCNT_EN
    logic [7:0] r_errcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_errcnt <= '0;
        end else if (r_state == S_ACK && w_err && r_errcnt != 8'hFF) begin
            r_errcnt <= r_errcnt + 8'd1;
        end
    end

    assign err_count = r_errcnt;
`endif
endmodule

// File: tb/tb_avl2mem.sv
// Directed bench for avl2mem: one instance with 1 wait state,
// one with 0 wait states and a 16-word RAM for range checks.
`timescale 1ns/1ps
module tb_avl2mem;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    avl2mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) a_if ();
    avl2mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b_if ();

`ifdef AVL2MEM_ERRCNT_EN
    logic [7:0] a_err;
    logic [7:0] b_err;
`endif

    avl2mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .MEM_WORDS(1024), .WAIT_STATES(1)
    ) u_a (
        .clk(clk),
        .reset(reset),
`ifdef AVL2MEM_ERRCNT_EN
        .err_count(a_err),
`endif
        .bus(a_if)
    );

    avl2mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .MEM_WORDS(16), .WAIT_STATES(0)
    ) u_b (
        .clk(clk),
        .reset(reset),
`ifdef AVL2MEM_ERRCNT_EN
        .err_count(b_err),
`endif
        .bus(b_if)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(bit sel, bit rd, bit wr, logic [31:0] ad,
                         logic [31:0] wd, logic [3:0] be);
        if (!sel) begin
            a_if.read = rd; a_if.write = wr; a_if.address = ad;
            a_if.writedata = wd; a_if.byteenable = be;
        end else begin
            b_if.read = rd; b_if.write = wr; b_if.address = ad;
            b_if.writedata = wd; b_if.byteenable = be;
        end
    endtask

    function automatic logic wreq(bit sel);
        return sel ? b_if.waitrequest : a_if.waitrequest;
    endfunction

    function automatic logic [31:0] rdat(bit sel);
        return sel ? b_if.readdata : a_if.readdata;
    endfunction

    // full handshake; returns ACK data, waitrequest cycles,
    // OR of readdata while waiting, readdata in the following IDLE
    task automatic xfer(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic [3:0] be,
                        output logic [31:0] ack_d, output int wc,
                        output logic [31:0] wait_d,
                        output logic [31:0] post_d);
        @(negedge clk);
        drive(sel, rd, wr, ad, wd, be);
        #1;
        wc = 0;
        wait_d = '0;
        while (wreq(sel) && wc < 40) begin
            wait_d |= rdat(sel);
            wc++;
            @(negedge clk);
            #1;
        end
        ack_d = rdat(sel);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, ad, wd, be);
        @(negedge clk);
        post_d = rdat(sel);
    endtask

    task automatic wr_word(string tag, bit sel, logic [31:0] ad,
                           logic [31:0] wd, logic [3:0] be);
        logic [31:0] d, wd_o, pd;
        int wc;
        xfer(sel, 1'b0, 1'b1, ad, wd, be, d, wc, wd_o, pd);
        chk({tag, "_wc"}, 32'(wc), sel ? 32'd1 : 32'd2);
    endtask

    task automatic rd_word(string tag, bit sel, logic [31:0] ad,
                           logic [31:0] exp);
        logic [31:0] d, wd_o, pd;
        int wc;
        xfer(sel, 1'b1, 1'b0, ad, 32'h0, 4'h0, d, wc, wd_o, pd);
        chk({tag, "_data"}, d, exp);
        chk({tag, "_wc"}, 32'(wc), sel ? 32'd1 : 32'd2);
        chk({tag, "_rdwait"}, wd_o, 32'h0);
        chk({tag, "_rdpost"}, pd, 32'h0);
    endtask

    initial begin
        logic [31:0] d, wd_o, pd;
        int wc;

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("rst_rd_a", a_if.readdata, 32'h0);
        chk("rst_wr_a", 32'(a_if.waitrequest), 32'h0);
        chk("rst_rd_b", b_if.readdata, 32'h0);
        reset = 1'b1;

        wr_word("wrA5", 1'b0, 32'h10, 32'hA5A5A5A5, 4'hF);
        rd_word("rdA5", 1'b0, 32'h10, 32'hA5A5A5A5);

        wr_word("wr11", 1'b0, 32'h10, 32'h11223344, 4'hF);
        wr_word("wrBB", 1'b0, 32'h10, 32'h0000BB00, 4'h2);
        rd_word("merge", 1'b0, 32'h10, 32'h1122BB44);

        wr_word("be0", 1'b0, 32'h10, 32'hFFFFFFFF, 4'h0);
        rd_word("be0", 1'b0, 32'h10, 32'h1122BB44);
        rd_word("lowbits", 1'b0, 32'h13, 32'h1122BB44);

        xfer(1'b0, 1'b1, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF,
             d, wc, wd_o, pd);
        chk("rw_ack", d, 32'h0);
        chk("rw_wc", 32'(wc), 32'd2);
        rd_word("rw_rb", 1'b0, 32'h14, 32'hDEADBEEF);

        wr_word("w0", 1'b0, 32'h0, 32'h12345678, 4'hF);
        wr_word("oob_w", 1'b0, 32'h1000, 32'hFFFFFFFF, 4'hF);
        rd_word("oob_r", 1'b0, 32'h1000, 32'h0);
        rd_word("alias", 1'b0, 32'h0, 32'h12345678);

        // request withdrawn in WAIT
        wr_word("w55", 1'b0, 32'h24, 32'h00000055, 4'hF);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h24, 32'hCAFEF00D, 4'hF);
        #1;
        chk("drop_wr", 32'(a_if.waitrequest), 32'h0);
        rd_word("drop", 1'b0, 32'h24, 32'h00000055);

        // reset in WAIT aborts the write
        wr_word("w20", 1'b0, 32'h20, 32'h0, 4'hF);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        chk("mid_wait", 32'(a_if.waitrequest), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rd", a_if.readdata, 32'h0);
        chk("mid_wr", 32'(a_if.waitrequest), 32'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b1;
        rd_word("abort", 1'b0, 32'h20, 32'h0);

        // zero wait states
        wr_word("b_w", 1'b1, 32'h4, 32'h0BADCAFE, 4'hF);
        rd_word("b_r", 1'b1, 32'h4, 32'h0BADCAFE);
        wr_word("b_w15", 1'b1, 32'h3C, 32'h600DF00D, 4'hF);
        rd_word("b_r15", 1'b1, 32'h3C, 32'h600DF00D);
`ifdef AVL2MEM_ERRCNT_EN
        chk("err0", 32'(b_err), 32'h0);
`endif
        rd_word("b_oob", 1'b1, 32'h40, 32'h0);
`ifdef AVL2MEM_ERRCNT_EN
        chk("err1", 32'(b_err), 32'h1);
        for (int i = 0; i < 256; i++) begin
            xfer(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0,
                 d, wc, wd_o, pd);
        end
        chk("err_sat", 32'(b_err), 32'hFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
